instr_fetch_ctrl: RTL

- Sequences the combinational instruction ROM for the RV32I core.
- Drives the ROM word address from an internal fetch PC and buffers fetched words in a small queue.
- Presents instructions to decode over a valid/ready handshake and accepts PC redirects from branch/jump resolution.
- Stops fetching at an end-of-program sentinel or at the end of the ROM.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/instr_fetch_queue.sv | 46 ++++
 rtl/instr_fetch_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch FSM state, queue entry type and PC step for instr_fetch_ctrl
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/instr_fetch_queue.sv
// fetch_queue: circular FIFO of fetch_entry_t (clk, reset_n, push, pop, flush, din -> dout, empty, full, count); flush beats push, push+pop when full is legal
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  fetch_entry_t              din,
  output fetch_entry_t              dout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(QDEPTH):0]   count
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t   mem [QDEPTH];
  logic [AW-1:0]  wr, rd;
  logic           do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == CW'(QDEPTH);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else if (flush) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: ROM fetch sequencer (start/redirect in; imem_addr/imem_data ROM side; instr_valid/ready/data/pc to decode; busy, halted; fault when FETCH_ALIGN_CHECK_EN)
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter int          ROM_WORDS = 16,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        busy,
  output logic        halted
`ifdef FETCH_ALIGN_CHECK_EN
  , output logic      fault
`endif
);
  localparam int          CW        = $clog2(QDEPTH) + 1;
  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS * 4);
  fetch_state_e  state, state_n;
  logic [31:0]   fetch_pc, pc_n;
  fetch_entry_t  q_dout;
  logic          q_empty, q_full, q_push, q_flush;
  logic [CW-1:0] q_count;
  logic          pop, redir, restart, bad_align, in_rom, is_halt, drained;
  assign imem_addr   = fetch_pc;
  assign instr_valid = !q_empty;
  assign instr_data  = q_dout.instr;
  assign instr_pc    = q_dout.pc;
  assign busy        = state == FETCH || state == DRAIN;
  assign halted      = state == HALT;
  assign pop         = instr_valid && instr_ready;
  assign redir       = redirect_valid && state != IDLE;
  assign restart     = start && (state == IDLE || state == HALT);
`ifdef FETCH_ALIGN_CHECK_EN
  assign bad_align   = redir && redirect_pc[1:0] != 2'b00;
`else
  assign bad_align   = 1'b0;
`endif
  assign in_rom      = fetch_pc < ROM_LIMIT;
  assign is_halt     = imem_data == HALT_WORD;
  assign drained     = q_empty || (q_count == CW'(1) && pop);
  assign q_flush     = redir || restart;
  assign q_push      = state == FETCH && !redir && in_rom && !is_halt && (!q_full || pop);
  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    if (redir) begin
      state_n = bad_align ? HALT : FETCH;
      pc_n    = bad_align ? fetch_pc : redirect_pc & ~32'd3;
    end else if (restart) begin
      state_n = FETCH;
      pc_n    = RESET_PC;
    end else if (state == FETCH) begin
      state_n = (!in_rom || is_halt) ? DRAIN : FETCH;
      pc_n    = q_push ? fetch_pc + PC_STEP : fetch_pc;
    end else if (state == DRAIN) begin
      state_n = drained ? HALT : DRAIN;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
    end
  end
`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault <= 1'b0;
    else if (bad_align) fault <= 1'b1;
    else if (restart) fault <= 1'b0;
  end
`endif
  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (q_push),
    .pop     (pop),
    .flush   (q_flush),
    .din     ('{pc: fetch_pc, instr: imem_data}),
    .dout    (q_dout),
    .empty   (q_empty),
    .full    (q_full),
    .count   (q_count)
  );
endmodule
